// File: rtl/display_timing_pkg.sv
// rtl/display_timing_pkg.sv - video mode timing sets and total-length helper
//
// Purpose: shared timing constants for the progressive modes the timing
// generator is normally built for, plus a helper that sums the four segment
// lengths of one axis (active, front porch, sync, back porch).
// Ports: none (package).

package display_timing_pkg;

    typedef struct packed {
        int   h_active;
        int   h_fp;
        int   h_sync;
        int   h_bp;
        int   v_active;
        int   v_fp;
        int   v_sync;
        int   v_bp;
        logic h_pol;
        logic v_pol;
        int   pix_hz;
    } video_mode_t;

    // 640x480 @ 60 Hz, 25.175 MHz pixel clock, negative syncs.
    localparam video_mode_t MODE_640X480 = '{
        h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
        v_active: 480, v_fp: 10, v_sync: 2,  v_bp: 33,
        h_pol: 1'b0, v_pol: 1'b0, pix_hz: 25_175_000
    };

    // 800x600 @ 60 Hz, 40 MHz pixel clock, positive syncs.
    localparam video_mode_t MODE_800X600 = '{
        h_active: 800, h_fp: 40, h_sync: 128, h_bp: 88,
        v_active: 600, v_fp: 1,  v_sync: 4,   v_bp: 23,
        h_pol: 1'b1, v_pol: 1'b1, pix_hz: 40_000_000
    };

    // 1280x720 @ 60 Hz, 74.25 MHz pixel clock, positive syncs.
    localparam video_mode_t MODE_1280X720 = '{
        h_active: 1280, h_fp: 110, h_sync: 40, h_bp: 220,
        v_active: 720,  v_fp: 5,   v_sync: 5,  v_bp: 20,
        h_pol: 1'b1, v_pol: 1'b1, pix_hz: 74_250_000
    };

    function automatic int timing_total(input int active, input int fp,
                                        input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/display_timing_axis.sv
// rtl/display_timing_axis.sv - one timing axis: wrapping counter plus registered sync flag
//
// Purpose: position counter for one screen axis (horizontal or vertical) with
// wrap detection and a registered sync output describing the pre-update
// position.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   adv        advance the position counter this cycle
//   upd        capture the sync flag from the current position this cycle
//   pos        current position (registered)
//   wrap       position is the last one of the axis (combinational)
//   in_active  position lies in the active region (combinational)
//   sync       registered sync level, polarity POL

module display_timing_axis
    import display_timing_pkg::*;
#(
    parameter int   CORDW  = 10,
    parameter int   ACTIVE = 640,
    parameter int   FP     = 16,
    parameter int   SYNC   = 96,
    parameter int   BP     = 48,
    parameter logic POL    = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adv,
    input  logic             upd,
    output logic [CORDW-1:0] pos,
    output logic             wrap,
    output logic             in_active,
    output logic             sync
);

    localparam int TOTAL = timing_total(ACTIVE, FP, SYNC, BP);

    localparam logic [CORDW-1:0] LAST     = CORDW'(TOTAL - 1);
    localparam logic [CORDW-1:0] ACT_END  = CORDW'(ACTIVE);
    localparam logic [CORDW-1:0] SYNC_STA = CORDW'(ACTIVE + FP);
    localparam logic [CORDW-1:0] SYNC_END = CORDW'(ACTIVE + FP + SYNC - 1);

    if (TOTAL > (1 << CORDW)) begin : g_bad_width
        $error("display_timing_axis: total %0d does not fit in %0d bits", TOTAL, CORDW);
    end

    if (ACTIVE < 1 || FP < 1 || SYNC < 1 || BP < 1) begin : g_bad_segment
        $error("display_timing_axis: every timing segment must be at least 1");
    end

    logic in_sync;

    assign wrap      = (pos == LAST);
    assign in_active = (pos < ACT_END);
    assign in_sync   = (pos >= SYNC_STA) && (pos <= SYNC_END);

    always_ff @(posedge clk) begin
        if (rst) begin
            pos  <= '0;
            sync <= ~POL;
        end else begin
            if (adv) begin
                pos <= wrap ? '0 : pos + CORDW'(1);
            end
            // Sync is taken from the position before this update, so it
            // trails the coordinate by one pixel step.
            if (upd) begin
                sync <= in_sync ? POL : ~POL;
            end
        end
    end

endmodule

// File: rtl/display_timing_regs.sv
// rtl/display_timing_regs.sv - progressive video timing generator with registered syncs and strobes
//
// Purpose: produces screen coordinates sx/sy and registered hsync, vsync and de
// that describe the previous coordinate, plus single-clock line, frame and
// vblank strobes for framebuffer and interrupt logic.
// Ports:
//   clk_pix       pixel-domain clock
//   rst_pix       synchronous active-high reset, overrides pix_en
//   pix_en        pixel advance enable (tie high for a native pixel clock)
//   sx, sy        current screen position
//   hsync, vsync  registered syncs, polarity H_POL / V_POL
//   de            registered data enable
//   line_start    one-clock pulse when a line begins
//   frame_start   one-clock pulse when a frame begins
//   vblank_start  one-clock pulse when vertical blanking begins

module display_timing_regs
    import display_timing_pkg::*;
#(
    parameter int   CORDW    = 10,
    parameter int   H_ACTIVE = MODE_640X480.h_active,
    parameter int   H_FP     = MODE_640X480.h_fp,
    parameter int   H_SYNC   = MODE_640X480.h_sync,
    parameter int   H_BP     = MODE_640X480.h_bp,
    parameter int   V_ACTIVE = MODE_640X480.v_active,
    parameter int   V_FP     = MODE_640X480.v_fp,
    parameter int   V_SYNC   = MODE_640X480.v_sync,
    parameter int   V_BP     = MODE_640X480.v_bp,
    parameter logic H_POL    = MODE_640X480.h_pol,
    parameter logic V_POL    = MODE_640X480.v_pol
) (
    input  logic             clk_pix,
    input  logic             rst_pix,
    input  logic             pix_en,
    output logic [CORDW-1:0] sx,
    output logic [CORDW-1:0] sy,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic             line_start,
    output logic             frame_start,
    output logic             vblank_start
);

    localparam logic [CORDW-1:0] VBLANK_LINE = CORDW'(V_ACTIVE);

    logic h_wrap;
    logic h_in_active;
    logic v_in_active;
    logic v_wrap_unused;   // end-of-frame marker, not needed at this level
    logic v_adv;

    // The vertical axis steps once per line, on the pixel that wraps sx.
    assign v_adv = pix_en & h_wrap;

    display_timing_axis #(
        .CORDW  (CORDW),
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .POL    (H_POL)
    ) u_h_axis (
        .clk       (clk_pix),
        .rst       (rst_pix),
        .adv       (pix_en),
        .upd       (pix_en),
        .pos       (sx),
        .wrap      (h_wrap),
        .in_active (h_in_active),
        .sync      (hsync)
    );

    // Sync is refreshed on every pixel step, so vsync edges line up with
    // the hsync pipeline even though the line count moves once per line.
    display_timing_axis #(
        .CORDW  (CORDW),
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .POL    (V_POL)
    ) u_v_axis (
        .clk       (clk_pix),
        .rst       (rst_pix),
        .adv       (v_adv),
        .upd       (pix_en),
        .pos       (sy),
        .wrap      (v_wrap_unused),
        .in_active (v_in_active),
        .sync      (vsync)
    );

    logic at_line_head;

    assign at_line_head = pix_en && (sx == '0);

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            de           <= 1'b0;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
            vblank_start <= 1'b0;
        end else begin
            if (pix_en) begin
                de <= h_in_active & v_in_active;
            end
            // Strobes are evaluated every clock so they stay one clock wide
            // regardless of how slowly pix_en steps.
            line_start   <= at_line_head;
            frame_start  <= at_line_head && (sy == '0);
            vblank_start <= at_line_head && (sy == VBLANK_LINE);
        end
    end

endmodule

// File: tb/tb_display_timing_regs.sv
// tb/tb_display_timing_regs.sv - self-checking bench for display_timing_regs

module tb_display_timing_regs;

    typedef struct {
        int         cyc;
        logic [9:0] sx;
        logic [9:0] sy;
        logic       hs;
        logic       vs;
        logic       de;
        logic       ls;
        logic       fs;
        logic       vb;
    } vec_t;

    logic clk_pix = 1'b0;
    always #5 clk_pix = ~clk_pix;

    logic rst_pix;
    logic pix_en_a;
    logic pix_en_b;

    logic [9:0] sx_a, sy_a;
    logic       hs_a, vs_a, de_a, ls_a, fs_a, vb_a;
    logic [3:0] sx_b, sy_b;
    logic       hs_b, vs_b, de_b, ls_b, fs_b, vb_b;

    display_timing_regs dut_a (
        .clk_pix      (clk_pix),
        .rst_pix      (rst_pix),
        .pix_en       (pix_en_a),
        .sx           (sx_a),
        .sy           (sy_a),
        .hsync        (hs_a),
        .vsync        (vs_a),
        .de           (de_a),
        .line_start   (ls_a),
        .frame_start  (fs_a),
        .vblank_start (vb_a)
    );

    display_timing_regs #(
        .CORDW    (4),
        .H_ACTIVE (8),
        .H_FP     (2),
        .H_SYNC   (3),
        .H_BP     (2),
        .V_ACTIVE (4),
        .V_FP     (1),
        .V_SYNC   (2),
        .V_BP     (1),
        .H_POL    (1'b1),
        .V_POL    (1'b1)
    ) dut_b (
        .clk_pix      (clk_pix),
        .rst_pix      (rst_pix),
        .pix_en       (pix_en_b),
        .sx           (sx_b),
        .sy           (sy_b),
        .hsync        (hs_b),
        .vsync        (vs_b),
        .de           (de_b),
        .line_start   (ls_b),
        .frame_start  (fs_b),
        .vblank_start (vb_b)
    );

    int checks   = 0;
    int failures = 0;

    // Reference for the small mode: H 8/2/3/2 (total 15, sync 10..12),
    // V 4/1/2/1 (total 8, sync 5..6), both syncs active high.
    int   m_sx = 0, m_sy = 0;
    logic m_hs = 0, m_vs = 0, m_de = 0, m_ls = 0, m_fs = 0, m_vb = 0;
    bit   m_valid = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        int osx = m_sx;
        int osy = m_sy;
        if (rst_pix) begin
            m_sx = 0; m_sy = 0;
            m_hs = 1'b0; m_vs = 1'b0; m_de = 1'b0;
            m_ls = 1'b0; m_fs = 1'b0; m_vb = 1'b0;
            m_valid = 1;
        end else begin
            m_ls = pix_en_b && (osx == 0);
            m_fs = m_ls && (osy == 0);
            m_vb = m_ls && (osy == 4);
            if (pix_en_b) begin
                m_hs = (osx >= 10) && (osx <= 12);
                m_vs = (osy >= 5) && (osy <= 6);
                m_de = (osx < 8) && (osy < 4);
                if (osx == 14) begin
                    m_sx = 0;
                    m_sy = (osy == 7) ? 0 : osy + 1;
                end else begin
                    m_sx = osx + 1;
                end
            end
        end
        @(posedge clk_pix);
        #1;
        if (m_valid) begin
            check("small_mode_cycle",
                  {sx_b, sy_b, hs_b, vs_b, de_b, ls_b, fs_b, vb_b},
                  {4'(m_sx), 4'(m_sy), m_hs, m_vs, m_de, m_ls, m_fs, m_vb});
        end
    endtask

    task automatic check_vec(input string name, input vec_t v);
        check(name,
              {sx_a, sy_a, hs_a, vs_a, de_a, ls_a, fs_a, vb_a},
              {v.sx, v.sy, v.hs, v.vs, v.de, v.ls, v.fs, v.vb});
    endtask

    vec_t tbl[15];
    vec_t rst_vec;
    vec_t rel_vec;

    initial begin
        int ti;
        int de_n, hsl_n, vsl_n, ls_n, fs_n, vb_n;
        int bhs_n, bvs_n, bde_n, bls_n, bfs_n, bvb_n;
        int fs_first, fs_second, wide_n;
        logic prev_ls, prev_fs, prev_vb;

        //            cyc   sx   sy  hs vs de ls fs vb
        tbl[0]  = '{  0,    0,   0,  1, 1, 0, 0, 0, 0};
        tbl[1]  = '{  1,    1,   0,  1, 1, 1, 1, 1, 0};
        tbl[2]  = '{  2,    2,   0,  1, 1, 1, 0, 0, 0};
        tbl[3]  = '{  640,  640, 0,  1, 1, 1, 0, 0, 0};
        tbl[4]  = '{  641,  641, 0,  1, 1, 0, 0, 0, 0};
        tbl[5]  = '{  656,  656, 0,  1, 1, 0, 0, 0, 0};
        tbl[6]  = '{  657,  657, 0,  0, 1, 0, 0, 0, 0};
        tbl[7]  = '{  752,  752, 0,  0, 1, 0, 0, 0, 0};
        tbl[8]  = '{  753,  753, 0,  1, 1, 0, 0, 0, 0};
        tbl[9]  = '{  799,  799, 0,  1, 1, 0, 0, 0, 0};
        tbl[10] = '{  800,  0,   1,  1, 1, 0, 0, 0, 0};
        tbl[11] = '{  801,  1,   1,  1, 1, 1, 1, 0, 0};
        tbl[12] = '{  1600, 0,   2,  1, 1, 0, 0, 0, 0};
        tbl[13] = '{  1601, 1,   2,  1, 1, 1, 1, 0, 0};
        tbl[14] = '{  2400, 0,   3,  1, 1, 0, 0, 0, 0};
        rst_vec = tbl[0];
        rel_vec = tbl[1];

        rst_pix  = 1'b1;
        pix_en_a = 1'b1;
        pix_en_b = 1'b1;
        step();
        step();
        check_vec("reset_state", tbl[0]);

        // Free-running default mode for three lines; small mode for two frames.
        rst_pix = 1'b0;
        ti = 1;
        de_n = 0; hsl_n = 0; vsl_n = 0; ls_n = 0; fs_n = 0; vb_n = 0;
        bhs_n = 0; bvs_n = 0; bde_n = 0; bls_n = 0; bfs_n = 0; bvb_n = 0;
        for (int k = 1; k <= 2400; k++) begin
            step();
            de_n  += int'(de_a);
            hsl_n += int'(!hs_a);
            vsl_n += int'(!vs_a);
            ls_n  += int'(ls_a);
            fs_n  += int'(fs_a);
            vb_n  += int'(vb_a);
            if (k <= 240) begin
                bhs_n += int'(hs_b);
                bvs_n += int'(vs_b);
                bde_n += int'(de_b);
                bls_n += int'(ls_b);
                bfs_n += int'(fs_b);
                bvb_n += int'(vb_b);
            end
            if (ti < 15 && tbl[ti].cyc == k) begin
                check_vec($sformatf("vec_cyc%0d", k), tbl[ti]);
                ti++;
            end
        end
        check("de_high_3lines",    de_n,  1920);
        check("hsync_low_3lines",  hsl_n, 288);
        check("vsync_low_3lines",  vsl_n, 0);
        check("line_start_count",  ls_n,  3);
        check("frame_start_count", fs_n,  1);
        check("vblank_count_top",  vb_n,  0);
        check("small_hsync_high",  bhs_n, 48);
        check("small_vsync_high",  bvs_n, 60);
        check("small_de_high",     bde_n, 64);
        check("small_line_starts", bls_n, 16);
        check("small_frame_starts", bfs_n, 2);
        check("small_vblank_starts", bvb_n, 2);

        // Hold with pix_en low: position and syncs frozen, strobes quiet.
        pix_en_a = 1'b0;
        pix_en_b = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_default", {sx_a, sy_a, de_a, hs_a, vs_a, ls_a, fs_a},
                  {10'd0, 10'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
        end
        pix_en_a = 1'b1;
        step();
        check("resume_default", {sx_a, sy_a, de_a, ls_a, fs_a},
              {10'd1, 10'd3, 1'b1, 1'b1, 1'b0});

        // Reset mid-line with de active.
        for (int i = 0; i < 299; i++) step();
        check("before_reset_de", {sx_a, sy_a, de_a, hs_a}, {10'd300, 10'd3, 1'b1, 1'b1});
        rst_pix = 1'b1;
        step();
        check_vec("reset_mid_de", rst_vec);
        rst_pix = 1'b0;
        step();
        check_vec("restart_after_de", rel_vec);

        // Reset inside the hsync pulse.
        for (int i = 0; i < 699; i++) step();
        check("before_reset_hs", {sx_a, sy_a, hs_a, de_a}, {10'd700, 10'd0, 1'b0, 1'b0});
        rst_pix = 1'b1;
        step();
        check_vec("reset_mid_hsync", rst_vec);
        rst_pix = 1'b0;
        step();
        check_vec("restart_after_hs", rel_vec);

        // Small mode stepped one clock in four.
        rst_pix = 1'b1;
        step();
        rst_pix = 1'b0;
        fs_n = 0; ls_n = 0; vb_n = 0; wide_n = 0;
        fs_first = -1; fs_second = -1;
        prev_ls = 1'b0; prev_fs = 1'b0; prev_vb = 1'b0;
        for (int i = 0; i < 960; i++) begin
            pix_en_b = (i % 4 == 0);
            step();
            if (fs_b) begin
                if (fs_n == 0) fs_first = i;
                else if (fs_n == 1) fs_second = i;
                fs_n++;
            end
            ls_n += int'(ls_b);
            vb_n += int'(vb_b);
            if ((ls_b && prev_ls) || (fs_b && prev_fs) || (vb_b && prev_vb)) wide_n++;
            prev_ls = ls_b;
            prev_fs = fs_b;
            prev_vb = vb_b;
        end
        check("slow_frame_starts", fs_n, 2);
        check("slow_first_frame",  fs_first, 0);
        check("slow_frame_period", fs_second - fs_first, 480);
        check("slow_line_starts",  ls_n, 16);
        check("slow_vblank_starts", vb_n, 2);
        check("slow_strobe_width", wide_n, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
